color_freq_decoder: RTL and testbench

- Receiver for the colour sensors' square-wave output, used once for the object sensor and once for the station sensor.
- Drives the sensor filter-select pins through red, green and blue in turn and counts output edges in a fixed gate window per filter.
- Classifies the dominant colour and hands the result to Core as object_color or station_color information.
- Measurement is one-shot, triggered by start.

---
 rtl/color_freq_decoder.sv | 189 ++++++++++++++++++
 tb/tb_color_freq_decoder.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/color_freq_decoder.sv
`default_nettype none
// ============================================================================
// Module   : color_freq_decoder
// Function : Steps a colour sensor through R/G/B filters, counts square-wave
//            edges in a fixed gate per filter and classifies the dominant colour.
// Revision : 1.0
// ============================================================================
module color_freq_decoder #(
    parameter int SETTLE_CYCLES = 5000,
    parameter int GATE_CYCLES   = 500000,
    parameter int CNT_W         = 16,
    parameter int MIN_COUNT     = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sensor_in,
    input  logic             start,
    output logic [1:0]       filter_sel,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] red_cnt,
    output logic [CNT_W-1:0] green_cnt,
    output logic [CNT_W-1:0] blue_cnt,
    output logic [1:0]       color
);

    localparam int TMAX  = (SETTLE_CYCLES > GATE_CYCLES) ? SETTLE_CYCLES : GATE_CYCLES;
    localparam int TMR_W = $clog2(TMAX + 1);

    localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYCLES - 1);
    localparam logic [TMR_W-1:0] GATE_LAST   = TMR_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W:0]   MIN_EXT     = (CNT_W + 1)'(MIN_COUNT);

    localparam logic [1:0] FS_RED   = 2'b00;
    localparam logic [1:0] FS_GREEN = 2'b11;
    localparam logic [1:0] FS_BLUE  = 2'b01;
    localparam logic [1:0] FS_CLEAR = 2'b10;

    localparam logic [1:0] CH_RED   = 2'd0;
    localparam logic [1:0] CH_GREEN = 2'd1;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_SETTLE   = 3'd1,
        S_GATE     = 3'd2,
        S_CLASSIFY = 3'd3,
        S_DONE     = 3'd4
    } state_t;

    state_t           state;
    logic [1:0]       ch;
    logic [TMR_W-1:0] tmr;
    logic [2:0]       sync_q;
    logic             rise;
    logic [CNT_W-1:0] work;
    logic [CNT_W-1:0] work_inc;
    logic [CNT_W-1:0] hold_r;
    logic [CNT_W-1:0] hold_g;
    logic [CNT_W-1:0] hold_b;
    logic [1:0]       class_color;

    // sync_q[1] is the synchronised level, sync_q[2] its one-cycle delay
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= 3'b000;
        end else begin
            sync_q <= {sync_q[1:0], sensor_in};
        end
    end

    assign rise = sync_q[1] & ~sync_q[2];

    always_comb begin
        work_inc = work;
        if (rise && (work != {CNT_W{1'b1}})) begin
            work_inc = work + 1'b1;
        end
    end

    // Widened by one bit so y + y/4 cannot overflow
    function automatic logic dominant(input logic [CNT_W-1:0] x,
                                      input logic [CNT_W-1:0] a,
                                      input logic [CNT_W-1:0] b);
        logic [CNT_W:0] xe;
        logic [CNT_W:0] ae;
        logic [CNT_W:0] be;
        xe = {1'b0, x};
        ae = {1'b0, a};
        be = {1'b0, b};
        return (xe >= MIN_EXT) && (xe > ae + (ae >> 2)) && (xe > be + (be >> 2));
    endfunction

    always_comb begin
        class_color = 2'd0;
        if (dominant(hold_r, hold_g, hold_b)) begin
            class_color = 2'd1;
        end else if (dominant(hold_g, hold_r, hold_b)) begin
            class_color = 2'd2;
        end else if (dominant(hold_b, hold_r, hold_g)) begin
            class_color = 2'd3;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            ch         <= CH_RED;
            tmr        <= '0;
            work       <= '0;
            hold_r     <= '0;
            hold_g     <= '0;
            hold_b     <= '0;
            filter_sel <= FS_CLEAR;
            busy       <= 1'b0;
            done       <= 1'b0;
            red_cnt    <= '0;
            green_cnt  <= '0;
            blue_cnt   <= '0;
            color      <= 2'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    done       <= 1'b0;
                    filter_sel <= FS_CLEAR;
                    if (start) begin
                        state      <= S_SETTLE;
                        ch         <= CH_RED;
                        tmr        <= '0;
                        work       <= '0;
                        filter_sel <= FS_RED;
                        busy       <= 1'b1;
                    end
                end
                S_SETTLE: begin
                    if (tmr == SETTLE_LAST) begin
                        tmr   <= '0;
                        state <= S_GATE;
                    end else begin
                        tmr <= tmr + 1'b1;
                    end
                end
                S_GATE: begin
                    work <= work_inc;
                    if (tmr == GATE_LAST) begin
                        tmr <= '0;
                        if (ch == CH_RED) begin
                            hold_r     <= work_inc;
                            ch         <= CH_GREEN;
                            filter_sel <= FS_GREEN;
                            work       <= '0;
                            state      <= S_SETTLE;
                        end else if (ch == CH_GREEN) begin
                            hold_g     <= work_inc;
                            ch         <= 2'd2;
                            filter_sel <= FS_BLUE;
                            work       <= '0;
                            state      <= S_SETTLE;
                        end else begin
                            hold_b <= work_inc;
                            state  <= S_CLASSIFY;
                        end
                    end else begin
                        tmr <= tmr + 1'b1;
                    end
                end
                S_CLASSIFY: begin
                    // Outputs are registered here so they change during the DONE cycle
                    red_cnt    <= hold_r;
                    green_cnt  <= hold_g;
                    blue_cnt   <= hold_b;
                    color      <= class_color;
                    done       <= 1'b1;
                    busy       <= 1'b0;
                    filter_sel <= FS_CLEAR;
                    state      <= S_DONE;
                end
                S_DONE: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_color_freq_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_color_freq_decoder
// Function : Scoreboard bench for color_freq_decoder (16-bit and 4-bit counters).
// Revision : 1.0
// ============================================================================
module tb_color_freq_decoder;

    localparam int SETTLE = 4;
    localparam int GATE   = 100;
    localparam int LAT    = 3 * (SETTLE + GATE) + 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        sensor_in;
    logic        start;
    logic [1:0]  filter_sel_a, filter_sel_b;
    logic        busy_a, busy_b, done_a, done_b;
    logic [15:0] red_a, green_a, blue_a;
    logic [3:0]  red_b, green_b, blue_b;
    logic [1:0]  color_a, color_b;

    color_freq_decoder #(.SETTLE_CYCLES(SETTLE), .GATE_CYCLES(GATE), .CNT_W(16), .MIN_COUNT(4)) dut_a (
        .clk(clk), .rst(rst), .sensor_in(sensor_in), .start(start),
        .filter_sel(filter_sel_a), .busy(busy_a), .done(done_a),
        .red_cnt(red_a), .green_cnt(green_a), .blue_cnt(blue_a), .color(color_a)
    );

    color_freq_decoder #(.SETTLE_CYCLES(SETTLE), .GATE_CYCLES(GATE), .CNT_W(4), .MIN_COUNT(4)) dut_b (
        .clk(clk), .rst(rst), .sensor_in(sensor_in), .start(start),
        .filter_sel(filter_sel_b), .busy(busy_b), .done(done_b),
        .red_cnt(red_b), .green_cnt(green_b), .blue_cnt(blue_b), .color(color_b)
    );

    always #5 clk = ~clk;

    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        int     er, eg, eb, ec;
        int     erb, ecb;
        longint acc;
    } exp_t;

    exp_t exp_q[$];

    // Sensor model: per filter, number of rising edges and period in cycles
    int cfg_n[3];
    int cfg_p[3];

    task automatic set_cfg(input int nr, input int pr, input int ng, input int pg,
                           input int nb, input int pb);
        cfg_n[0] = nr; cfg_p[0] = pr;
        cfg_n[1] = ng; cfg_p[1] = pg;
        cfg_n[2] = nb; cfg_p[2] = pb;
    endtask

    initial begin : sensor_model
        logic [1:0] prev;
        int ch;
        sensor_in = 1'b0;
        prev = 2'b10;
        forever begin
            @(negedge clk);
            if (filter_sel_a != prev) begin
                prev = filter_sel_a;
                ch = (prev == 2'b00) ? 0 : (prev == 2'b11) ? 1 : (prev == 2'b01) ? 2 : -1;
                if (ch >= 0) begin
                    // first rise lands well inside the gate, after settle
                    repeat (3) @(negedge clk);
                    for (int k = 0; k < cfg_n[ch]; k++) begin
                        sensor_in = 1'b1;
                        repeat (cfg_p[ch] / 2) @(negedge clk);
                        sensor_in = 1'b0;
                        if (k != cfg_n[ch] - 1) repeat (cfg_p[ch] - cfg_p[ch] / 2) @(negedge clk);
                    end
                end
            end
        end
    end

    logic [1:0] fs_log[$];
    bit         fs_rec = 1'b0;
    initial begin : fs_recorder
        forever begin
            @(negedge clk);
            if (fs_rec && filter_sel_a != fs_log[fs_log.size()-1]) fs_log.push_back(filter_sel_a);
        end
    end

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (done_a || done_b) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL spurious_done: actual=1 required=0 (cycle %0d)", cyc);
                end else begin
                    e = exp_q.pop_front();
                    chk("done_a", {31'd0, done_a}, 1);
                    chk("done_b", {31'd0, done_b}, 1);
                    chk("red_a", red_a, e.er);
                    chk("green_a", green_a, e.eg);
                    chk("blue_a", blue_a, e.eb);
                    chk("color_a", color_a, e.ec);
                    chk("red_b", red_b, e.erb);
                    chk("green_b", green_b, e.eg);
                    chk("blue_b", blue_b, e.eb);
                    chk("color_b", color_b, e.ecb);
                    chk("busy_at_done", {31'd0, busy_a}, 0);
                    chk("latency", 32'(cyc - e.acc + 1), LAT);
                end
            end
        end
    end

    task automatic wait_idle(input int bound);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !busy_a) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL timeout: actual=busy required=idle (cycle %0d)", cyc);
            exp_q.delete();
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_vec(input int er, input int eg, input int eb, input int ec,
                           input int erb, input int ecb);
        exp_t e;
        pulse_start();
        e = '{er: er, eg: eg, eb: eb, ec: ec, erb: erb, ecb: ecb, acc: cyc};
        exp_q.push_back(e);
        wait_idle(LAT + 50);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        logic [1:0] fs_exp[5];
        exp_t e;
        bit   got;
        rst   = 1'b1;
        start = 1'b0;
        set_cfg(0, 10, 0, 10, 0, 10);
        repeat (3) @(negedge clk);
        chk("rst_red", red_a, 0);
        chk("rst_color", color_a, 0);
        chk("rst_busy", {31'd0, busy_a}, 0);
        chk("rst_done", {31'd0, done_a}, 0);
        chk("rst_filter", filter_sel_a, 2'b10);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // red object
        set_cfg(10, 10, 5, 20, 4, 25);
        run_vec(10, 5, 4, 1, 10, 1);
        // ambiguous: 10 > 9 + 2 fails
        set_cfg(10, 10, 9, 10, 4, 10);
        run_vec(10, 9, 4, 0, 10, 0);
        // dark scene
        set_cfg(3, 10, 1, 10, 1, 10);
        run_vec(3, 1, 1, 0, 3, 0);
        // blue: 8 > 6 + 1
        set_cfg(2, 10, 6, 10, 8, 10);
        run_vec(2, 6, 8, 3, 2, 3);
        // green: 12 > 5 + 1
        set_cfg(3, 10, 12, 8, 5, 10);
        run_vec(3, 12, 5, 2, 3, 2);
        // saturation of the 4-bit instance
        set_cfg(20, 4, 2, 10, 1, 10);
        run_vec(20, 2, 1, 1, 15, 1);

        // reset in the middle of the red gate
        set_cfg(10, 10, 5, 20, 4, 25);
        pulse_start();
        repeat (50) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort_red", red_a, 0);
        chk("abort_green", green_a, 0);
        chk("abort_blue", blue_a, 0);
        chk("abort_red_b", red_b, 0);
        chk("abort_color", color_a, 0);
        chk("abort_busy", {31'd0, busy_a}, 0);
        chk("abort_done", {31'd0, done_a}, 0);
        chk("abort_filter", filter_sel_a, 2'b10);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (400) @(negedge clk);
        chk("post_abort_color", color_a, 0);

        // second start mid-measurement is ignored
        fs_log = '{filter_sel_a};
        fs_rec = 1'b1;
        pulse_start();
        e = '{er: 10, eg: 5, eb: 4, ec: 1, erb: 10, ecb: 1, acc: cyc};
        exp_q.push_back(e);
        repeat (150) @(negedge clk);
        pulse_start();
        wait_idle(LAT + 50);
        repeat (350) @(negedge clk);
        fs_rec = 1'b0;
        fs_exp = '{2'b10, 2'b00, 2'b11, 2'b01, 2'b10};
        chk("fs_len", fs_log.size(), 5);
        for (int i = 0; i < 5 && i < fs_log.size(); i++) chk($sformatf("fs_seq%0d", i), fs_log[i], fs_exp[i]);

        // start held high: back-to-back with one idle cycle between
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        e = '{er: 10, eg: 5, eb: 4, ec: 1, erb: 10, ecb: 1, acc: cyc};
        exp_q.push_back(e);
        got = 1'b0;
        for (int i = 0; i < LAT + 50; i++) begin
            @(negedge clk);
            if (done_a) begin
                got = 1'b1;
                break;
            end
        end
        chk("held_first_done", {31'd0, got}, 1);
        e.acc = cyc + 2;
        exp_q.push_back(e);
        @(negedge clk);
        chk("held_idle_gap", {31'd0, busy_a}, 0);
        @(negedge clk);
        chk("held_rebusy", {31'd0, busy_a}, 1);
        start = 1'b0;
        wait_idle(LAT + 50);

        repeat (20) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
